// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with 2-bit saturating counters.
// Fetch-stage lookup is combinational. Each prediction rides alongside its
// instruction through Decode and Execute. Execute compares the prediction
// against the resolved outcome to flag a mispredict and supply the corrected
// PC. It also trains the BTB.
module branch_predictor #(
    parameter int INDEX_BITS = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] PCF,
    input  logic        StallDecode,
    input  logic        FlushDecode,
    input  logic        StallExecute,
    input  logic        FlushExecute,
    input  logic        BranchE,
    input  logic        JumpE,
    input  logic        TakenE,
    input  logic [31:0] PCE,
    input  logic [31:0] PCTargetE,
    output logic        PredictTakenF,
    output logic [31:0] PredictTargetF,
    output logic        branch_mispredict_o,
    output logic [31:0] CorrectPCE
);

    localparam int ENTRIES = 1 << INDEX_BITS;
    localparam int TAG_W   = 32 - INDEX_BITS - 2;

    // BTB storage; only the valid bits are reset
    logic [ENTRIES-1:0] valid;
    logic [TAG_W-1:0]   tag_mem    [ENTRIES];
    logic [31:0]        target_mem [ENTRIES];
    logic [1:0]         ctr_mem    [ENTRIES];

    // Prediction carried with the instruction: _p1 = Decode, _p2 = Execute
    logic        pt_p1;
    logic [31:0] ptgt_p1;
    logic        pt_p2;
    logic [31:0] ptgt_p2;

    logic [INDEX_BITS-1:0] idx_f;
    logic [TAG_W-1:0]      tag_f;
    logic                  hit_f;
    logic [INDEX_BITS-1:0] idx_e;
    logic [TAG_W-1:0]      tag_e;
    logic                  hit_e;
    logic                  taken_e;
    logic                  upd_en;

    function automatic logic [1:0] ctr_inc(input logic [1:0] c);
        return (c == 2'b11) ? c : c + 2'd1;
    endfunction

    function automatic logic [1:0] ctr_dec(input logic [1:0] c);
        return (c == 2'b00) ? c : c - 2'd1;
    endfunction

    // Fetch lookup: zero-latency, no bypass of a same-cycle update
    assign idx_f          = PCF[INDEX_BITS+1:2];
    assign tag_f          = PCF[31:INDEX_BITS+2];
    assign hit_f          = valid[idx_f] && (tag_mem[idx_f] == tag_f);
    assign PredictTakenF  = hit_f && ctr_mem[idx_f][1];
    assign PredictTargetF = PredictTakenF ? target_mem[idx_f] : PCF + 32'd4;

    // Execute resolve: JAL is always taken; a stale pt=1 on a non-branch
    // mispredicts back to the fall-through PC
    assign taken_e             = JumpE | (BranchE & TakenE);
    assign CorrectPCE          = taken_e ? PCTargetE : PCE + 32'd4;
    assign branch_mispredict_o = (pt_p2 != taken_e) ||
                                 (taken_e && pt_p2 && (ptgt_p2 != PCTargetE));

    assign idx_e  = PCE[INDEX_BITS+1:2];
    assign tag_e  = PCE[31:INDEX_BITS+2];
    assign hit_e  = valid[idx_e] && (tag_mem[idx_e] == tag_e);
    // Holding off while Execute stalls gives exactly one update per branch
    assign upd_en = (BranchE | JumpE) & ~StallExecute;

    // F->D prediction register
    always_ff @(posedge clk) begin
        if (rst || FlushDecode) begin
            pt_p1   <= 1'b0;
            ptgt_p1 <= 32'd0;
        end else if (!StallDecode) begin
            pt_p1   <= PredictTakenF;
            ptgt_p1 <= PredictTargetF;
        end
    end

    // ---- Decode / Execute boundary ----
    // D->E prediction register
    always_ff @(posedge clk) begin
        if (rst || FlushExecute) begin
            pt_p2   <= 1'b0;
            ptgt_p2 <= 32'd0;
        end else if (!StallExecute) begin
            pt_p2   <= pt_p1;
            ptgt_p2 <= ptgt_p1;
        end
    end

    // Valid bits: cleared on reset, set when a taken miss allocates
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= '0;
        end else if (upd_en && taken_e && !hit_e) begin
            valid[idx_e] <= 1'b1;
        end
    end

    // Tag/target/counter training; an update coinciding with reset is dropped
    always_ff @(posedge clk) begin
        if (!rst && upd_en) begin
            if (hit_e) begin
                if (taken_e) begin
                    ctr_mem[idx_e]    <= ctr_inc(ctr_mem[idx_e]);
                    target_mem[idx_e] <= PCTargetE;
                end else begin
                    ctr_mem[idx_e]    <= ctr_dec(ctr_mem[idx_e]);
                end
            end else if (taken_e) begin
                tag_mem[idx_e]    <= tag_e;
                target_mem[idx_e] <= PCTargetE;
                ctr_mem[idx_e]    <= 2'b10;
            end
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: a vector table walks the main
// allocate/train/predict flow, then hand-written sequences cover reset,
// stalls, flushes, JAL and not-taken misses.
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] PCF;
    logic        StallDecode, FlushDecode, StallExecute, FlushExecute;
    logic        BranchE, JumpE, TakenE;
    logic [31:0] PCE, PCTargetE;
    logic        PredictTakenF;
    logic [31:0] PredictTargetF;
    logic        branch_mispredict_o;
    logic [31:0] CorrectPCE;

    int n_tests = 0;
    int n_fail  = 0;

    branch_predictor #(.INDEX_BITS(6)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .PCF                 (PCF),
        .StallDecode         (StallDecode),
        .FlushDecode         (FlushDecode),
        .StallExecute        (StallExecute),
        .FlushExecute        (FlushExecute),
        .BranchE             (BranchE),
        .JumpE               (JumpE),
        .TakenE              (TakenE),
        .PCE                 (PCE),
        .PCTargetE           (PCTargetE),
        .PredictTakenF       (PredictTakenF),
        .PredictTargetF      (PredictTargetF),
        .branch_mispredict_o (branch_mispredict_o),
        .CorrectPCE          (CorrectPCE)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        rst;
        logic [31:0] pcf;
        logic        br;
        logic        jmp;
        logic        tk;
        logic [31:0] pce;
        logic [31:0] ptgt;
        logic        chk;
        logic        ept;
        logic [31:0] etgt;
        logic        emis;
        logic [31:0] ecpc;
        logic        cc;
        logic [1:0]  ectr;
    } vec_t;

    vec_t tv [17];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_in();
        rst = 0; PCF = 32'h10;
        StallDecode = 0; FlushDecode = 0; StallExecute = 0; FlushExecute = 0;
        BranchE = 0; JumpE = 0; TakenE = 0; PCE = 32'h0; PCTargetE = 32'h0;
    endtask

    task automatic check_f(input string nm, input logic ept, input logic [31:0] etgt);
        #1;
        check({nm, "_pt"}, {31'd0, PredictTakenF}, {31'd0, ept});
        check({nm, "_tgt"}, PredictTargetF, etgt);
    endtask

    task automatic check_e(input string nm, input logic emis, input logic [31:0] ecpc);
        #1;
        check({nm, "_mis"}, {31'd0, branch_mispredict_o}, {31'd0, emis});
        check({nm, "_cpc"}, CorrectPCE, ecpc);
    endtask

    initial begin
        // rst pcf br jmp tk pce ptgt | chk ept etgt emis ecpc cc ectr
        tv[0]  = '{1'b1, 32'h100, 1'b0, 1'b0, 1'b0, 32'h0,   32'h0,  1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 2'd0};
        tv[1]  = '{1'b0, 32'h100, 1'b0, 1'b0, 1'b0, 32'h0,   32'h0,  1'b1, 1'b0, 32'h104, 1'b0, 32'h4,   1'b0, 2'd0};
        tv[2]  = '{1'b0, 32'h10,  1'b1, 1'b0, 1'b1, 32'h100, 32'h80, 1'b1, 1'b0, 32'h14,  1'b1, 32'h80,  1'b0, 2'd0};
        tv[3]  = '{1'b0, 32'h100, 1'b0, 1'b0, 1'b0, 32'h0,   32'h0,  1'b1, 1'b1, 32'h80,  1'b0, 32'h4,   1'b1, 2'd2};
        tv[4]  = '{1'b0, 32'h10,  1'b0, 1'b0, 1'b0, 32'h0,   32'h0,  1'b1, 1'b0, 32'h14,  1'b0, 32'h4,   1'b1, 2'd2};
        tv[5]  = '{1'b0, 32'h10,  1'b1, 1'b0, 1'b1, 32'h100, 32'h80, 1'b1, 1'b0, 32'h14,  1'b0, 32'h80,  1'b1, 2'd2};
        tv[6]  = '{1'b0, 32'h10,  1'b1, 1'b0, 1'b1, 32'h100, 32'h80, 1'b1, 1'b0, 32'h14,  1'b1, 32'h80,  1'b1, 2'd3};
        tv[7]  = '{1'b0, 32'h10,  1'b1, 1'b0, 1'b1, 32'h100, 32'h80, 1'b1, 1'b0, 32'h14,  1'b1, 32'h80,  1'b1, 2'd3};
        tv[8]  = '{1'b0, 32'h10,  1'b1, 1'b0, 1'b0, 32'h100, 32'h80, 1'b1, 1'b0, 32'h14,  1'b0, 32'h104, 1'b1, 2'd3};
        tv[9]  = '{1'b0, 32'h100, 1'b0, 1'b0, 1'b0, 32'h0,   32'h0,  1'b1, 1'b1, 32'h80,  1'b0, 32'h4,   1'b1, 2'd2};
        tv[10] = '{1'b0, 32'h10,  1'b1, 1'b0, 1'b0, 32'h100, 32'h80, 1'b1, 1'b0, 32'h14,  1'b0, 32'h104, 1'b1, 2'd2};
        tv[11] = '{1'b0, 32'h100, 1'b0, 1'b0, 1'b0, 32'h100, 32'h0,  1'b1, 1'b0, 32'h104, 1'b1, 32'h104, 1'b1, 2'd1};
        tv[12] = '{1'b0, 32'h10,  1'b1, 1'b0, 1'b1, 32'h100, 32'h80, 1'b1, 1'b0, 32'h14,  1'b1, 32'h80,  1'b1, 2'd1};
        tv[13] = '{1'b0, 32'h100, 1'b0, 1'b0, 1'b0, 32'h0,   32'h0,  1'b1, 1'b1, 32'h80,  1'b0, 32'h4,   1'b1, 2'd2};
        tv[14] = '{1'b0, 32'h10,  1'b0, 1'b0, 1'b0, 32'h0,   32'h0,  1'b1, 1'b0, 32'h14,  1'b0, 32'h4,   1'b1, 2'd2};
        tv[15] = '{1'b0, 32'h10,  1'b1, 1'b0, 1'b1, 32'h100, 32'h90, 1'b1, 1'b0, 32'h14,  1'b1, 32'h90,  1'b1, 2'd2};
        tv[16] = '{1'b0, 32'h100, 1'b0, 1'b0, 1'b0, 32'h0,   32'h0,  1'b1, 1'b1, 32'h90,  1'b0, 32'h4,   1'b1, 2'd3};

        idle_in();
        @(negedge clk);

        for (int i = 0; i < 17; i++) begin
            rst = tv[i].rst; PCF = tv[i].pcf;
            BranchE = tv[i].br; JumpE = tv[i].jmp; TakenE = tv[i].tk;
            PCE = tv[i].pce; PCTargetE = tv[i].ptgt;
            #1;
            if (tv[i].chk) begin
                check($sformatf("v%0d_pt", i), {31'd0, PredictTakenF}, {31'd0, tv[i].ept});
                check($sformatf("v%0d_tgt", i), PredictTargetF, tv[i].etgt);
                check($sformatf("v%0d_mis", i), {31'd0, branch_mispredict_o}, {31'd0, tv[i].emis});
                check($sformatf("v%0d_cpc", i), CorrectPCE, tv[i].ecpc);
            end
            if (tv[i].cc)
                check($sformatf("v%0d_ctr", i), {30'd0, dut.ctr_mem[0]}, {30'd0, tv[i].ectr});
            tick();
        end

        // Reset mid-operation with a stall and an update pending
        idle_in();
        rst = 1; StallExecute = 1; BranchE = 1; TakenE = 1; PCE = 32'h204; PCTargetE = 32'h400;
        tick();
        idle_in();
        PCF = 32'h100;
        check_f("rst_mid_f", 1'b0, 32'h104);
        check_e("rst_mid_e", 1'b0, 32'h4);
        check("rst_mid_ptd", {31'd0, dut.pt_p1}, 32'd0);
        tick();

        // Update during reset was dropped; now allocate 0x204
        idle_in();
        PCF = 32'h204; BranchE = 1; TakenE = 1; PCE = 32'h204; PCTargetE = 32'h400;
        check_f("drop_upd", 1'b0, 32'h208);
        check_e("alloc_204", 1'b1, 32'h400);
        tick();
        check("alloc_ctr", {30'd0, dut.ctr_mem[1]}, 32'd2);

        // Cache stall: five held cycles, one update when it drops
        idle_in();
        StallExecute = 1; BranchE = 1; TakenE = 1; PCE = 32'h204; PCTargetE = 32'h400;
        for (int k = 0; k < 5; k++) tick();
        #1;
        check("stall_ctr_hold", {30'd0, dut.ctr_mem[1]}, 32'd2);
        StallExecute = 0;
        tick();
        idle_in();
        #1;
        check("stall_ctr_once", {30'd0, dut.ctr_mem[1]}, 32'd3);

        // Load-use: D holds its prediction, E gets a bubble
        PCF = 32'h204;
        check_f("lu_lookup", 1'b1, 32'h400);
        tick();
        idle_in();
        StallDecode = 1; FlushExecute = 1;
        tick();
        idle_in();
        #1;
        check("lu_ptd", {31'd0, dut.pt_p1}, 32'd1);
        check("lu_ptgtd", dut.ptgt_p1, 32'h400);
        check("lu_pte", {31'd0, dut.pt_p2}, 32'd0);
        tick();
        BranchE = 1; TakenE = 1; PCE = 32'h204; PCTargetE = 32'h400;
        check_e("lu_correct", 1'b0, 32'h400);
        tick();

        // FlushExecute discards a pt=1 heading into Execute
        idle_in();
        PCF = 32'h204;
        tick();
        idle_in();
        FlushExecute = 1;
        tick();
        idle_in();
        PCE = 32'h204;
        check_e("flushe_nomis", 1'b0, 32'h208);
        tick();

        // FlushDecode clears the fetched prediction
        idle_in();
        PCF = 32'h204; FlushDecode = 1;
        tick();
        idle_in();
        #1;
        check("flushd_ptd", {31'd0, dut.pt_p1}, 32'd0);
        tick();
        PCE = 32'h204;
        check_e("flushd_nomis", 1'b0, 32'h208);
        tick();

        // StallExecute holds the Execute prediction
        idle_in();
        PCF = 32'h204;
        tick();
        idle_in();
        tick();
        StallExecute = 1;
        tick();
        idle_in();
        BranchE = 1; TakenE = 1; PCE = 32'h204; PCTargetE = 32'h400;
        check_e("stalle_hold", 1'b0, 32'h400);
        tick();

        // JAL with TakenE low still takes and allocates
        idle_in();
        JumpE = 1; TakenE = 0; PCE = 32'h208; PCTargetE = 32'h500;
        check_e("jal_e", 1'b1, 32'h500);
        tick();
        idle_in();
        PCF = 32'h208;
        check_f("jal_f", 1'b1, 32'h500);
        tick();

        // Not-taken miss does not allocate
        idle_in();
        BranchE = 1; TakenE = 0; PCE = 32'h20C; PCTargetE = 32'h600;
        check_e("nt_miss_e", 1'b0, 32'h210);
        tick();
        idle_in();
        PCF = 32'h20C;
        check_f("nt_miss_f", 1'b0, 32'h210);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
